// File: rtl/srl_fifo_param.sv
// srl_fifo_param: shift-register FIFO with first-word-fall-through output,
// almost-full flag, sticky overflow/underflow flags and synchronous flush.
// Newest word sits in position 0; the oldest word is at position count-1.
module srl_fifo_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 2,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err_ovf,
  output logic                  err_udf
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_udf_q, err_udf_d;
  logic                  wr_req, rd_req;
  logic                  wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] rd_idx;

  // Flags decode straight from the registered occupancy.
  assign if_full_n        = (count_q != DEPTH_C);
  assign if_empty_n       = (count_q != '0);
  assign if_almost_full_n = (count_q < AFULL_C);
  assign count            = count_q;
  assign err_ovf          = err_ovf_q;
  assign err_udf          = err_udf_q;

  assign wr_req = if_write & if_write_ce;
  assign rd_req = if_read & if_read_ce;
  assign wr_acc = wr_req & if_full_n;
  assign rd_acc = rd_req & if_empty_n;

  // Oldest word index; wraps harmlessly when empty since dout is don't-care then.
  assign rd_idx  = count_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
  assign if_dout = mem_q[rd_idx];

  // Shift every word up one slot and insert the new word at slot 0 on an accepted write.
  always_comb begin
    mem_d = mem_q;
    if (wr_acc) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
      mem_d[0] = if_din;
    end
  end

  // Storage carries no reset; occupancy alone decides which words are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Next occupancy and sticky error flags; flush overrides everything else.
  always_comb begin
    count_d   = count_q;
    err_ovf_d = err_ovf_q | (wr_req & ~if_full_n);
    err_udf_d = err_udf_q | (rd_req & ~if_empty_n);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    if (flush) begin
      count_d   = '0;
      err_ovf_d = 1'b0;
      err_udf_d = 1'b0;
    end
  end

  // Occupancy and error state registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

endmodule

// File: tb/tb_srl_fifo_param.sv
// tb_srl_fifo_param: directed table-driven bench for srl_fifo_param with
// DEPTH=4, DATA_WIDTH=8, AFULL_THRESH=3, plus a hand-written mid-cycle reset sequence.
module tb_srl_fifo_param;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic       if_write_ce;
  logic       if_write;
  logic [7:0] if_din;
  logic       if_full_n;
  logic       if_almost_full_n;
  logic       if_read_ce;
  logic       if_read;
  logic [7:0] if_dout;
  logic       if_empty_n;
  logic [2:0] count;
  logic       err_ovf;
  logic       err_udf;

  int errors = 0;
  int checks = 0;

  srl_fifo_param #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (2),
    .DEPTH       (4),
    .AFULL_THRESH(3)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush           (flush),
    .if_write_ce     (if_write_ce),
    .if_write        (if_write),
    .if_din          (if_din),
    .if_full_n       (if_full_n),
    .if_almost_full_n(if_almost_full_n),
    .if_read_ce      (if_read_ce),
    .if_read         (if_read),
    .if_dout         (if_dout),
    .if_empty_n      (if_empty_n),
    .count           (count),
    .err_ovf         (err_ovf),
    .err_udf         (err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       wce;
    logic       wr;
    logic [7:0] din;
    logic       rce;
    logic       rd;
    int         cnt;
    logic [7:0] dout;
    logic       dchk;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, input logic wce, input logic wr, input logic [7:0] din,
                     input logic rce, input logic rd, input int cnt, input logic [7:0] dout,
                     input logic dchk, input logic ovf, input logic udf);
    vec_t v;
    v.fl = fl; v.wce = wce; v.wr = wr; v.din = din; v.rce = rce; v.rd = rd;
    v.cnt = cnt; v.dout = dout; v.dchk = dchk; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected flags follow from the expected occupancy: full at 4, almost-full from 3.
  task automatic check_state(input string tag, input int cnt, input logic [7:0] dout,
                             input logic dchk, input logic ovf, input logic udf);
    chk({tag, " count"},         int'(count),            cnt);
    chk({tag, " full_n"},        int'(if_full_n),        (cnt != 4) ? 1 : 0);
    chk({tag, " almost_full_n"}, int'(if_almost_full_n), (cnt < 3) ? 1 : 0);
    chk({tag, " empty_n"},       int'(if_empty_n),       (cnt != 0) ? 1 : 0);
    chk({tag, " err_ovf"},       int'(err_ovf),          int'(ovf));
    chk({tag, " err_udf"},       int'(err_udf),          int'(udf));
    if (dchk) chk({tag, " dout"}, int'(if_dout), int'(dout));
  endtask

  task automatic step(input logic fl, input logic wce, input logic wr, input logic [7:0] din,
                      input logic rce, input logic rd);
    flush = fl; if_write_ce = wce; if_write = wr; if_din = din;
    if_read_ce = rce; if_read = rd;
    @(posedge clk);
    #1;
    flush = 1'b0; if_write_ce = 1'b0; if_write = 1'b0; if_read_ce = 1'b0; if_read = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; if_write_ce = 1'b0; if_write = 1'b0; if_din = '0;
    if_read_ce = 1'b0; if_read = 1'b0;

    // In-order fill/drain and flag thresholds
    add(0,1,1,8'h11,0,0, 1,8'h11,1,0,0);
    add(0,1,1,8'h22,0,0, 2,8'h11,1,0,0);
    add(0,1,1,8'h33,0,0, 3,8'h11,1,0,0);
    add(0,1,1,8'h44,0,0, 4,8'h11,1,0,0);
    add(0,0,0,8'h00,1,1, 3,8'h22,1,0,0);
    add(0,0,0,8'h00,1,1, 2,8'h33,1,0,0);
    add(0,0,0,8'h00,1,1, 1,8'h44,1,0,0);
    add(0,0,0,8'h00,1,1, 0,8'h00,0,0,0);
    // Write+read at full: write dropped, overflow flagged, flush clears
    add(0,1,1,8'h11,0,0, 1,8'h11,1,0,0);
    add(0,1,1,8'h22,0,0, 2,8'h11,1,0,0);
    add(0,1,1,8'h33,0,0, 3,8'h11,1,0,0);
    add(0,1,1,8'h44,0,0, 4,8'h11,1,0,0);
    add(0,1,1,8'h55,1,1, 3,8'h22,1,1,0);
    add(0,0,0,8'h00,1,1, 2,8'h33,1,1,0);
    add(0,0,0,8'h00,1,1, 1,8'h44,1,1,0);
    add(1,0,0,8'h00,0,0, 0,8'h00,0,0,0);
    // Simultaneous write+read mid-occupancy
    add(0,1,1,8'hA0,0,0, 1,8'hA0,1,0,0);
    add(0,1,1,8'hA1,0,0, 2,8'hA0,1,0,0);
    add(0,1,1,8'hA2,1,1, 2,8'hA1,1,0,0);
    add(0,0,0,8'h00,1,1, 1,8'hA2,1,0,0);
    add(0,0,0,8'h00,1,1, 0,8'h00,0,0,0);
    // Write+read when empty: no pop, underflow flagged
    add(0,1,1,8'h77,1,1, 1,8'h77,1,0,1);
    add(0,0,0,8'h00,1,1, 0,8'h00,0,0,1);
    add(1,0,0,8'h00,0,0, 0,8'h00,0,0,0);
    // Clock enables gate requests, including for error flags
    add(0,1,1,8'h01,0,0, 1,8'h01,1,0,0);
    add(0,1,1,8'h02,0,0, 2,8'h01,1,0,0);
    add(0,1,1,8'h03,0,0, 3,8'h01,1,0,0);
    add(0,1,1,8'h04,0,0, 4,8'h01,1,0,0);
    add(0,0,1,8'h99,0,0, 4,8'h01,1,0,0);
    add(0,0,0,8'h00,0,1, 4,8'h01,1,0,0);
    add(0,1,1,8'h99,0,0, 4,8'h01,1,1,0);
    add(1,1,1,8'h5A,1,1, 0,8'h00,0,0,0);
    add(0,0,1,8'h66,0,0, 0,8'h00,0,0,0);
    add(0,0,0,8'h00,0,1, 0,8'h00,0,0,0);
    add(0,0,0,8'h00,1,1, 0,8'h00,0,0,1);
    add(1,0,0,8'h00,0,0, 0,8'h00,0,0,0);

    // Reset state while held
    #2;
    check_state("reset", 0, 8'h00, 0, 0, 0);
    // Release between edges; the first write lands on the next edge
    #10;
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].fl, vecs[i].wce, vecs[i].wr, vecs[i].din, vecs[i].rce, vecs[i].rd);
      check_state($sformatf("v%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].dchk,
                  vecs[i].ovf, vecs[i].udf);
    end

    // Mid-operation asynchronous reset discards stored words
    step(0,1,1,8'hC1,0,0);
    step(0,1,1,8'hC2,0,0);
    step(0,1,1,8'hC3,0,0);
    check_state("pre_rst", 3, 8'hC1, 1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_state("async_rst", 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_state("rst_release", 0, 8'h00, 0, 0, 0);
    step(0,0,0,8'h00,1,1);
    check_state("rst_read", 0, 8'h00, 0, 0, 1);
    step(0,1,1,8'hD7,0,0);
    check_state("rst_write", 1, 8'hD7, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/srl_fifo_param.md
SRL_FIFO_PARAM -- requirements
Module: srl_fifo_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each stored word.
REQ-002 Parameter ADDR_WIDTH, default 2: read-index width; 2**ADDR_WIDTH >= DEPTH.
REQ-003 Parameter DEPTH, default 4: capacity in words; DEPTH >= 2.
REQ-004 Parameter AFULL_THRESH, default 3: almost-full level; 1 <= AFULL_THRESH <= DEPTH.
REQ-005 clk  input  1: single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1: reset, asynchronous assert, active-low.
REQ-007 flush  input  1: synchronous clear of occupancy and error flags.
REQ-008 if_write_ce  input  1: write-side clock enable.
REQ-009 if_write  input  1: write request.
REQ-010 if_din  input  DATA_WIDTH: write data.
REQ-011 if_full_n  output  1: high = space available.
REQ-012 if_almost_full_n  output  1: high = count < AFULL_THRESH.
REQ-013 if_read_ce  input  1: read-side clock enable.
REQ-014 if_read  input  1: read request (pop).
REQ-015 if_dout  output  DATA_WIDTH: oldest stored word, first-word-fall-through.
REQ-016 if_empty_n  output  1: high = at least one word stored.
REQ-017 count  output  ADDR_WIDTH+1: current occupancy, 0..DEPTH.
REQ-018 err_ovf  output  1: sticky, write requested while full.
REQ-019 err_udf  output  1: sticky, read requested while empty.

Function
REQ-020 Write accepted (wr_acc) SHALL be if_write & if_write_ce & if_full_n, all sampled the same cycle.
REQ-021 Read accepted (rd_acc) SHALL be if_read & if_read_ce & if_empty_n, all sampled the same cycle.
REQ-022 Storage SHALL be a shift-register array of DEPTH words; on wr_acc all words shift up one position and if_din enters position 0; no shift otherwise.
REQ-023 Storage array SHALL NOT be reset or flushed; only the occupancy state clears.
REQ-024 if_dout SHALL be combinational: storage[count-1] when count > 0; value is don't-care when if_empty_n = 0.
REQ-025 Next count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-026 Simultaneous wr_acc and rd_acc SHALL leave count unchanged; if_dout next cycle is the next-oldest word, with the new word behind it.
REQ-027 When full, a write SHALL NOT be accepted even if a read is accepted the same cycle; count goes DEPTH-1.
REQ-028 When empty, a read SHALL NOT be accepted even if a write is accepted the same cycle; count goes to 1.
REQ-029 Flags SHALL be decoded from the registered count: if_full_n = (count != DEPTH), if_empty_n = (count != 0), if_almost_full_n = (count < AFULL_THRESH).
REQ-030 Data written in cycle N SHALL be visible on if_dout with if_empty_n = 1 in cycle N+1 (1-cycle write-to-read latency).
REQ-031 err_ovf SHALL set the cycle after if_write & if_write_ce & ~if_full_n and hold until flush or reset.
REQ-032 err_udf SHALL set the cycle after if_read & if_read_ce & ~if_empty_n and hold until flush or reset.
REQ-033 flush SHALL take priority over any same-cycle read/write: next cycle count = 0, err_ovf = err_udf = 0; the storage shift still occurs if wr_acc was true.
REQ-034 With ce low on a side, that side's request SHALL be ignored, including for error-flag purposes.

Reset
REQ-035 reset_n low SHALL immediately force count = 0, if_full_n = 1, if_almost_full_n = 1, if_empty_n = 0, err_ovf = 0, err_udf = 0, independent of clk.
REQ-036 Deassertion SHALL be taken synchronously; the first accepted write occurs on the first rising edge with reset_n high.
REQ-037 Reset mid-operation SHALL discard all stored words logically; any read before a new write is an underflow.

Verification (DEPTH=4, DATA_WIDTH=8, AFULL_THRESH=3)
REQ-038 Write 0x11,0x22,0x33,0x44 on consecutive cycles, then read 4 -> dout 0x11,0x22,0x33,0x44 in order; full_n low only at count 4; almost_full_n low at count 3 and 4; empty_n low at the end.
REQ-039 At full (count 4), write 0x55 with read -> read returns 0x11, 0x55 dropped, count 3, err_ovf = 1; then flush -> count 0, err_ovf = 0.
REQ-040 At count 2 holding 0xA0,0xA1, write 0xA2 with read -> dout 0xA0 consumed, count stays 2, next dout 0xA1 then 0xA2.
REQ-041 When empty, read with write 0x77 -> no pop, err_udf = 1, next cycle count 1, dout 0x77.
REQ-042 Write 3 words, assert reset_n low between clock edges -> flags show reset values immediately; after release, empty_n = 0 until a new write.
REQ-043 Hold if_write_ce = 0 with if_write = 1 at full -> count unchanged, err_ovf stays 0.
